leading_zero_counter: RTL and testbench



---
 rtl/basic_circuits_pkg.sv | 17 +
 rtl/leading_zero_counter_if.sv | 35 +++
 rtl/zero_check.sv | 16 +
 rtl/leading_zero_counter.sv | 111 +++++++++++
 tb/tb_leading_zero_counter.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/basic_circuits_pkg.sv
// Shared definitions for the basic_circuits slice.
//   lzc_state_t  : control states of the leading-zero/one counter
//   lzc_cnt_w(n) : width of a count that must hold every value 0..n
package basic_circuits_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } lzc_state_t;

  // Width needed to represent 0..n inclusive (n=32 -> 6 bits).
  function automatic int lzc_cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage : basic_circuits_pkg

// File: rtl/leading_zero_counter_if.sv
// Request/response bundle between the execute stage and the CLZ/CLO unit.
//   start     : request strobe (requester -> unit)
//   ones      : 1 = count leading ones, 0 = leading zeros
//   a         : N-bit operand
//   busy      : unit is scanning
//   done      : one-cycle result strobe
//   count     : result 0..N, held until the next accepted start
//   all_match : result equals N
interface leading_zero_counter_if
  import basic_circuits_pkg::*;
#(
  parameter int N = 32
);

  localparam int CNT_W = lzc_cnt_w(N);

  logic             start;
  logic             ones;
  logic [N-1:0]     a;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] count;
  logic             all_match;

  modport master (
    output start, ones, a,
    input  busy, done, count, all_match
  );

  modport slave (
    input  start, ones, a,
    output busy, done, count, all_match
  );

endinterface : leading_zero_counter_if

// File: rtl/zero_check.sv
// Zero detector for an N-bit slice.
//   in    : slice under test
//   zero  : every bit of in is 0
//   nzero : at least one bit of in is 1
module zero_check #(
  parameter int N = 4
) (
  input  logic [N-1:0] in,
  output logic         zero,
  output logic         nzero
);

  assign nzero = |in;
  assign zero  = ~nzero;

endmodule : zero_check

// File: rtl/leading_zero_counter.sv
// Multi-cycle count-leading-zeros / count-leading-ones unit (MIPS CLZ/CLO).
// The operand is captured on an accepted start (inverted for CLO so that
// both operations reduce to counting leading zeros), then scanned MSB-first
// CHUNK bits per cycle. The scan stops at the first non-zero chunk.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : slave side of leading_zero_counter_if
//          (start/ones/a in; busy/done/count/all_match out)
module leading_zero_counter
  import basic_circuits_pkg::*;
#(
  parameter int N     = 32,
  parameter int CHUNK = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  leading_zero_counter_if.slave bus
);

  localparam int CNT_W   = lzc_cnt_w(N);
  localparam int NCHUNKS = N / CHUNK;
  localparam int IDX_W   = (NCHUNKS > 1) ? $clog2(NCHUNKS) : 1;

  if ((CHUNK < 1) || (CHUNK > N) || ((N % CHUNK) != 0) ||
      ((CHUNK & (CHUNK - 1)) != 0)) begin : g_bad_param
    $fatal(1, "leading_zero_counter: CHUNK must be a power of two dividing N");
  end

  // Position of the most significant set bit, counted from the chunk MSB.
  // Only meaningful for a non-zero chunk; the highest set bit is the last
  // one assigned in the loop and therefore wins.
  function automatic logic [CNT_W-1:0] lz(input logic [CHUNK-1:0] v);
    lz = '0;
    for (int i = 0; i < CHUNK; i++) begin
      if (v[i]) lz = CNT_W'(CHUNK - 1 - i);
    end
  endfunction

  lzc_state_t       state_q, state_d;
  logic [N-1:0]     sreg_q;
  logic [IDX_W-1:0] idx_q;
  logic [CNT_W-1:0] count_q;
  logic             all_match_q;

  logic [CHUNK-1:0] top;
  logic             chunk_zero;
  logic             chunk_nzero;
  logic             accept;
  logic             last_chunk;

  assign top        = sreg_q[N-1 -: CHUNK];
  assign accept     = bus.start && ((state_q == IDLE) || (state_q == DONE));
  assign last_chunk = (idx_q == IDX_W'(NCHUNKS - 1));

  zero_check #(.N(CHUNK)) u_zero_check (
    .in    (top),
    .zero  (chunk_zero),
    .nzero (chunk_nzero)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = SCAN;
      SCAN: if (!chunk_zero || last_chunk) state_d = DONE;
      DONE: state_d = accept ? SCAN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath. An accepted start always reloads, including from DONE, which
  // gives back-to-back operation without an idle bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg_q      <= '0;
      idx_q       <= '0;
      count_q     <= '0;
      all_match_q <= 1'b0;
    end else if (accept) begin
      sreg_q      <= bus.ones ? ~bus.a : bus.a;
      idx_q       <= '0;
      count_q     <= '0;
      all_match_q <= 1'b0;
    end else if (state_q == SCAN) begin
      if (chunk_nzero) begin
        count_q <= count_q + lz(top);
      end else begin
        count_q <= count_q + CNT_W'(CHUNK);
        sreg_q  <= sreg_q << CHUNK;
        idx_q   <= idx_q + IDX_W'(1);
        if (last_chunk) all_match_q <= 1'b1;
      end
    end
  end

  // Every output comes straight from a register.
  assign bus.busy      = (state_q == SCAN);
  assign bus.done      = (state_q == DONE);
  assign bus.count     = count_q;
  assign bus.all_match = all_match_q;

endmodule : leading_zero_counter

// File: tb/tb_leading_zero_counter.sv
// Directed self-checking bench for leading_zero_counter (N=32, CHUNK=4).
module tb_leading_zero_counter;

  localparam int N = 32;
  localparam int CHUNK = 4;
  localparam int MAX_WAIT = 40;

  logic clk = 1'b0;
  logic rst;

  int errors = 0;
  int checks = 0;

  leading_zero_counter_if #(.N(N)) bus ();

  leading_zero_counter #(.N(N), .CHUNK(CHUNK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Launch one operation and wait (bounded) for done. lat is the cycle in
  // which done was seen, counted from the start edge (1 = cycle after it).
  task automatic run_op(input logic [N-1:0] op, input logic ones_i,
                        output int lat, output logic [5:0] cnt,
                        output logic am);
    @(negedge clk);
    bus.a     = op;
    bus.ones  = ones_i;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (bus.done !== 1'b1 && lat < MAX_WAIT) begin
      @(negedge clk);
      lat++;
    end
    cnt = bus.count;
    am  = bus.all_match;
  endtask

  task automatic test_reset();
    int pulses;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.ones  = 1'b0;
    bus.a     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.count, bus.all_match} !== 9'b0) begin
      errors++;
      $display("FAIL reset_init: busy=%b done=%b count=%0d all_match=%b want 0/0/0/0",
               bus.busy, bus.done, bus.count, bus.all_match);
    end
    rst = 1'b0;
    // Start an all-zero CLZ scan and reset it two cycles in.
    bus.a = '0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.count, bus.all_match} !== 9'b0) begin
      errors++;
      $display("FAIL reset_mid_scan: busy=%b done=%b count=%0d all_match=%b want 0/0/0/0",
               bus.busy, bus.done, bus.count, bus.all_match);
    end
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL reset_no_done: activity cycles=%0d want 0", pulses);
    end
  endtask

  typedef struct {
    logic [N-1:0] a;
    logic         ones;
    int           lat;
    int           cnt;
    logic         am;
  } vec_t;

  task automatic test_directed();
    vec_t v[5];
    int lat;
    logic [5:0] cnt;
    logic am;
    v[0] = '{32'h8000_0000, 1'b0, 2, 0,  1'b0};
    v[1] = '{32'h0001_0000, 1'b0, 5, 15, 1'b0};
    v[2] = '{32'h0000_0000, 1'b0, 9, 32, 1'b1};
    v[3] = '{32'hFFFF_FFFF, 1'b1, 9, 32, 1'b1};
    v[4] = '{32'hF0FF_FFFF, 1'b1, 3, 4,  1'b0};
    foreach (v[k]) begin
      run_op(v[k].a, v[k].ones, lat, cnt, am);
      checks++;
      if (lat != v[k].lat || cnt !== 6'(v[k].cnt) || am !== v[k].am) begin
        errors++;
        $display("FAIL directed[%0d] a=%h ones=%b: lat=%0d count=%0d all_match=%b want %0d/%0d/%b",
                 k, v[k].a, v[k].ones, lat, cnt, am, v[k].lat, v[k].cnt, v[k].am);
      end
    end
  endtask

  task automatic test_walking();
    int lat;
    logic [5:0] cnt;
    logic am;
    logic [N-1:0] op;
    for (int i = 0; i < N; i++) begin
      for (int m = 0; m < 2; m++) begin
        op = 32'h1 << i;
        if (m == 1) op = ~op;
        run_op(op, logic'(m), lat, cnt, am);
        checks++;
        if (cnt !== 6'(31 - i) || lat != (31 - i) / 4 + 2 || am !== 1'b0) begin
          errors++;
          $display("FAIL walking i=%0d ones=%0d: count=%0d lat=%0d all_match=%b want %0d/%0d/0",
                   i, m, cnt, lat, am, 31 - i, (31 - i) / 4 + 2);
        end
      end
    end
  endtask

  task automatic test_start_in_scan();
    int lat;
    // 0001_0000: CLZ=15, done in cycle 5. A start during SCAN must be dropped.
    @(negedge clk);
    bus.a = 32'h0001_0000;
    bus.ones = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = 32'h8000_0000;
    lat = 1;
    @(negedge clk);
    lat++;
    bus.start = 1'b1;
    @(negedge clk);
    lat++;
    bus.start = 1'b0;
    while (bus.done !== 1'b1 && lat < MAX_WAIT) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != 5 || bus.count !== 6'd15) begin
      errors++;
      $display("FAIL start_in_scan: lat=%0d count=%0d want 5/15", lat, bus.count);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.count !== 6'd15) begin
      errors++;
      $display("FAIL idle_hold: busy=%b done=%b count=%0d want 0/0/15",
               bus.busy, bus.done, bus.count);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    bus.a = '0;
    bus.ones = 1'b0;
    bus.start = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (bus.done !== 1'b1 && lat < MAX_WAIT);
    checks++;
    if (lat != 9 || bus.count !== 6'd32 || bus.all_match !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: lat=%0d count=%0d all_match=%b want 9/32/1",
               lat, bus.count, bus.all_match);
    end
    // New operand presented during DONE with start still high.
    bus.a = 32'h8000_0000;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.all_match !== 1'b0) begin
      errors++;
      $display("FAIL b2b_no_bubble: busy=%b done=%b all_match=%b want 1/0/0",
               bus.busy, bus.done, bus.all_match);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b1 || bus.count !== 6'd0 || bus.all_match !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: done=%b count=%0d all_match=%b want 1/0/0",
               bus.done, bus.count, bus.all_match);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done_width: done=%b busy=%b want 0/0", bus.done, bus.busy);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_walking();
    test_start_in_scan();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_leading_zero_counter
